// File: rtl/uart_div_engine_if.sv
// Byte-level UART handshake between the division engine and the board's uart_rx/uart_tx blocks.
// The engine connects through the slave modport; the UART side (or a bench) drives through master.
interface uart_div_engine_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    output rx_valid,
    output rx_data,
    output tx_busy,
    input  tx_start,
    input  tx_data
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  tx_busy,
    output tx_start,
    output tx_data
  );
endinterface

// File: rtl/uart_div_engine.sv
// UART-attached restoring divider: gathers dividend/divisor bytes, divides over WIDTH cycles,
// then streams quotient, remainder and a status byte back out of the transmitter.
module uart_div_engine #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RX_TIMEOUT = 2_000_000,
  parameter int unsigned TX_GAP     = 166_576
) (
  input  logic               clk,
  input  logic               rst,
  uart_div_engine_if.slave   uart_io,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o,
  output logic               div_zero_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam int unsigned N  = WIDTH / 8;
  localparam int unsigned NB = 2 * N;
  localparam int unsigned CW = $clog2(NB + 1);
  localparam int unsigned DW = $clog2(WIDTH);
  localparam int unsigned GW = $clog2(TX_GAP);
  localparam int unsigned IW = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;

  localparam logic [1:0] StRx  = 2'd0;
  localparam logic [1:0] StDiv = 2'd1;
  localparam logic [1:0] StFin = 2'd2;
  localparam logic [1:0] StTx  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]      tx_idx_q, tx_idx_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic [2*WIDTH-1:0] prem_q, prem_d;
  logic               div_zero_q, div_zero_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               timeout_fire;
  logic [CW-1:0]      wr_idx;
  logic               wr_hi;
  logic [CW+2:0]      byte_sh;
  logic [WIDTH-1:0]   byte_mask;
  logic [WIDTH-1:0]   byte_val;
  logic [2*WIDTH-1:0] div_sh;
  logic [2*WIDTH-1:0] step;
  logic               trial_ge;
  logic               tx_start;
  logic [7:0]         status;
  logic [7:0]         cur_byte;

  // A byte arriving in the cycle the timeout fires starts a fresh frame at index 0.
  assign timeout_fire = (RX_TIMEOUT != 0) && (byte_cnt_q != '0) && (idle_q == IW'(RX_TIMEOUT));
  assign wr_idx       = timeout_fire ? '0 : byte_cnt_q;
  assign wr_hi        = wr_idx >= CW'(N);
  assign byte_sh      = {(wr_hi ? (wr_idx - CW'(N)) : wr_idx), 3'b000};
  assign byte_mask    = WIDTH'(8'hFF) << byte_sh;
  assign byte_val     = WIDTH'(uart_io.rx_data) << byte_sh;

  // The bit shifted out of the top acts as a carry so divisors near 2^WIDTH still divide exactly.
  always_comb begin
    div_sh   = {prem_q[2*WIDTH-2:0], 1'b0};
    trial_ge = prem_q[2*WIDTH-1] || (div_sh[2*WIDTH-1:WIDTH] >= divisor_q);
    step     = div_sh;
    if (trial_ge) begin
      step[2*WIDTH-1:WIDTH] = div_sh[2*WIDTH-1:WIDTH] - divisor_q;
      step[0]               = 1'b1;
    end
  end

  assign status   = div_zero_q ? 8'hEE : 8'h00;
  assign cur_byte = 8'({status, remainder_q, quotient_q} >> {tx_idx_q, 3'b000});
  assign tx_start = (state_q == StTx) && !uart_io.tx_busy && (gap_q == '0);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tx_idx_d    = tx_idx_q;
    idle_d      = idle_q;
    div_cnt_d   = div_cnt_q;
    gap_d       = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    prem_d      = prem_q;
    div_zero_d  = div_zero_q;
    tx_data_d   = tx_data_q;

    case (state_q)
      StRx: begin
        if (timeout_fire) begin
          byte_cnt_d = '0;
          idle_d     = '0;
          dividend_d = '0;
          divisor_d  = '0;
        end else if (byte_cnt_q != '0) begin
          idle_d = idle_q + IW'(1);
        end
        if (uart_io.rx_valid) begin
          idle_d = '0;
          if (wr_hi) begin
            divisor_d = (divisor_d & ~byte_mask) | byte_val;
          end else begin
            dividend_d = (dividend_d & ~byte_mask) | byte_val;
          end
          byte_cnt_d = wr_idx + CW'(1);
          if (wr_idx == CW'(NB - 1)) begin
            byte_cnt_d = '0;
            if (divisor_d == '0) begin
              quotient_d  = '1;
              remainder_d = dividend_d;
              div_zero_d  = 1'b1;
              state_d     = StFin;
            end else begin
              prem_d    = {{WIDTH{1'b0}}, dividend_d};
              div_cnt_d = '0;
              state_d   = StDiv;
            end
          end
        end
      end
      StDiv: begin
        prem_d    = step;
        div_cnt_d = div_cnt_q + DW'(1);
        // Results are registered on the last iteration so they are visible in the done cycle.
        if (div_cnt_q == DW'(WIDTH - 1)) begin
          div_cnt_d   = '0;
          quotient_d  = step[WIDTH-1:0];
          remainder_d = step[2*WIDTH-1:WIDTH];
          div_zero_d  = 1'b0;
          state_d     = StFin;
        end
      end
      StFin: begin
        tx_idx_d = '0;
        state_d  = StTx;
      end
      StTx: begin
        if (tx_start) begin
          tx_data_d = cur_byte;
          gap_d     = GW'(TX_GAP - 1);
          if (tx_idx_q == CW'(NB)) begin
            tx_idx_d = '0;
            state_d  = StRx;
          end else begin
            tx_idx_d = tx_idx_q + CW'(1);
          end
        end
      end
      default: state_d = StRx;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRx;
      byte_cnt_q  <= '0;
      tx_idx_q    <= '0;
      idle_q      <= '0;
      div_cnt_q   <= '0;
      gap_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      prem_q      <= '0;
      div_zero_q  <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_idx_q    <= tx_idx_d;
      idle_q      <= idle_d;
      div_cnt_q   <= div_cnt_d;
      gap_q       <= gap_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      prem_q      <= prem_d;
      div_zero_q  <= div_zero_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // tx_data follows the byte being launched and then holds until the next launch.
  assign uart_io.tx_start = tx_start;
  assign uart_io.tx_data  = tx_start ? cur_byte : tx_data_q;

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;
  assign done_o      = (state_q == StFin);
  assign busy_o      = (state_q != StRx);

endmodule

// File: tb/tb_uart_div_engine.sv
// Directed bench for uart_div_engine: 16- and 32-bit instances, expected TX bytes kept in a
// scoreboard queue filled as each frame is sent and drained as the engine transmits.
module tb_uart_div_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_div_engine_if b16 ();
  uart_div_engine_if b32 ();

  logic [15:0] q16, r16;
  logic [31:0] q32, r32;
  logic        dz16, dn16, bz16, dz32, dn32, bz32;

  uart_div_engine #(.WIDTH(16), .RX_TIMEOUT(50), .TX_GAP(4)) dut16 (
    .clk(clk), .rst(rst), .uart_io(b16), .quotient_o(q16), .remainder_o(r16),
    .div_zero_o(dz16), .done_o(dn16), .busy_o(bz16)
  );

  uart_div_engine #(.WIDTH(32), .RX_TIMEOUT(50), .TX_GAP(4)) dut32 (
    .clk(clk), .rst(rst), .uart_io(b32), .quotient_o(q32), .remainder_o(r32),
    .div_zero_o(dz32), .done_o(dn32), .busy_o(bz32)
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [7:0]   exp_q[$];
  logic [63:0]  exp_quot, exp_rem;
  logic         exp_dz;
  int unsigned  k_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit w32, output logic ts, output logic [7:0] td,
                        output logic [63:0] qq, output logic [63:0] rr,
                        output logic dz, output logic dn, output logic bz);
    if (w32) begin
      ts = b32.tx_start; td = b32.tx_data; qq = 64'(q32); rr = 64'(r32);
      dz = dz32; dn = dn32; bz = bz32;
    end else begin
      ts = b16.tx_start; td = b16.tx_data; qq = 64'(q16); rr = 64'(r16);
      dz = dz16; dn = dn16; bz = bz16;
    end
  endtask

  task automatic send(input bit w32, input logic [7:0] b);
    @(posedge clk); #1;
    if (w32) begin b32.rx_valid = 1'b1; b32.rx_data = b; end
    else begin b16.rx_valid = 1'b1; b16.rx_data = b; end
    k_cyc = cyc;
    @(posedge clk); #1;
    b16.rx_valid = 1'b0;
    b32.rx_valid = 1'b0;
  endtask

  // Reference result from plain arithmetic; TX bytes queued in send order.
  task automatic frame(input bit w32, input logic [31:0] a, input logic [31:0] b);
    int nb = w32 ? 4 : 2;
    logic [31:0] q, r;
    logic [7:0]  st;
    if (b == 0) begin
      q = w32 ? 32'hFFFF_FFFF : 32'h0000_FFFF; r = a; st = 8'hEE; exp_dz = 1'b1;
    end else begin
      q = a / b; r = a % b; st = 8'h00; exp_dz = 1'b0;
    end
    exp_quot = 64'(q);
    exp_rem  = 64'(r);
    for (int i = 0; i < nb; i++) exp_q.push_back(q[8*i +: 8]);
    for (int i = 0; i < nb; i++) exp_q.push_back(r[8*i +: 8]);
    exp_q.push_back(st);
    for (int i = 0; i < nb; i++) send(w32, a[8*i +: 8]);
    for (int i = 0; i < nb; i++) send(w32, b[8*i +: 8]);
  endtask

  task automatic run(input bit w32, input int lat, input int hold);
    logic        ts, dz, dn, bz, got, first;
    logic [7:0]  td, e;
    logic [63:0] qq, rr;
    int unsigned d_cyc, prev, first_exp;
    int          idx;
    got = 1'b0; d_cyc = 0; prev = 0; idx = 0; first = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      sample(w32, ts, td, qq, rr, dz, dn, bz);
      if (dn) begin got = 1'b1; d_cyc = cyc; end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("done_latency", 64'(d_cyc - k_cyc), 64'(lat));
    chk("quotient", qq, exp_quot);
    chk("remainder", rr, exp_rem);
    chk("div_zero", 64'(dz), 64'(exp_dz));
    chk("busy_at_done", 64'(bz), 64'd1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        b16.rx_valid = (i == 3 || i == 7 || i == 11);
        b16.rx_data  = 8'h55;
      end
      b16.tx_busy = 1'b0;
      b16.rx_valid = 1'b0;
      first_exp = d_cyc + hold;
    end else begin
      first_exp = d_cyc + 1;
    end
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      sample(w32, ts, td, qq, rr, dz, dn, bz);
      if (ts) begin
        e = exp_q.pop_front();
        chk($sformatf("tx_byte%0d", idx), 64'(td), 64'(e));
        chk($sformatf("busy_tx%0d", idx), 64'(bz), 64'd1);
        if (first) chk("tx_first_cycle", 64'(cyc), 64'(first_exp));
        else       chk("tx_spacing", 64'(cyc - prev), 64'd4);
        prev  = cyc;
        first = 1'b0;
        idx++;
      end
    end
    chk("tx_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    sample(w32, ts, td, qq, rr, dz, dn, bz);
    chk("busy_after_tx", 64'(bz), 64'd0);
  endtask

  initial begin
    logic        ts, dz, dn, bz;
    logic [7:0]  td;
    logic [63:0] qq, rr;
    int          stray;
    b16.rx_valid = 1'b0; b16.rx_data = 8'h00; b16.tx_busy = 1'b0;
    b32.rx_valid = 1'b0; b32.rx_data = 8'h00; b32.tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sample(w[0], ts, td, qq, rr, dz, dn, bz);
      chk("rst_tx_start", 64'(ts), 64'd0);
      chk("rst_tx_data", 64'(td), 64'd0);
      chk("rst_quotient", qq, 64'd0);
      chk("rst_remainder", rr, 64'd0);
      chk("rst_flags", {61'd0, dz, dn, bz}, 64'd0);
    end

    frame(1'b0, 32'd1000, 32'd7);
    run(1'b0, 17, 0);

    frame(1'b0, 32'h1234, 32'd0);
    run(1'b0, 1, 0);

    // Partial frame abandoned by the idle timeout.
    send(1'b0, 8'hE8);
    send(1'b0, 8'h03);
    repeat (60) @(posedge clk);
    frame(1'b0, 32'd10, 32'd5);
    run(1'b0, 17, 0);

    // Reset pulse in the middle of a division.
    send(1'b0, 8'hE8); send(1'b0, 8'h03); send(1'b0, 8'h07); send(1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    sample(1'b0, ts, td, qq, rr, dz, dn, bz);
    chk("midrst_quotient", qq, 64'd0);
    chk("midrst_remainder", rr, 64'd0);
    chk("midrst_flags", {61'd0, dz, dn, bz}, 64'd0);
    chk("midrst_tx", {55'd0, ts, td}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b16.tx_start || dn16) stray++;
    end
    chk("midrst_no_activity", 64'(stray), 64'd0);
    frame(1'b0, 32'd100, 32'd10);
    run(1'b0, 17, 0);

    frame(1'b1, 32'hFFFF_FFFF, 32'd3);
    run(1'b1, 33, 0);

    // Transmitter held busy after done, with stray bytes arriving during TX.
    b16.tx_busy = 1'b1;
    frame(1'b0, 32'd50000, 32'd123);
    run(1'b0, 17, 20);
    frame(1'b0, 32'd60000, 32'd7);
    run(1'b0, 17, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_div_engine.md
# uart_div_engine

Parametrised UART-attached division engine. It collects a dividend and a divisor as little-endian byte streams from a UART receiver and runs a WIDTH-cycle restoring division. It then returns the quotient, the remainder and a status byte through a UART transmitter, and repeats for every frame. It sits between the board's uart_rx/uart_tx byte interfaces and the LED display. It adds three things to single-shot 16-bit operation: a generic width, divide-by-zero reporting and inter-byte timeout resync.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of 8 and at least 8. N = WIDTH/8 bytes per operand.
- RX_TIMEOUT, 2_000_000: idle clocks between received bytes after which a partial frame is discarded. 0 disables the timeout.
- TX_GAP, 166_576: minimum clocks from one tx_start to the next. Must be at least 2.
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy. tx_start is never issued while this is high.
- tx_start  out  1  one-cycle strobe: send tx_data.
- tx_data  out  8  byte to send. Held stable from tx_start until the next tx_start.
- quotient  out  WIDTH  last result quotient (for the LEDs).
- remainder  out  WIDTH  last result remainder.
- div_zero  out  1  last frame had divisor 0.
- done  out  1  one-cycle pulse when quotient/remainder update.
- busy  out  1  high whenever the engine is not in RX.

## Operation
- States:
  - RX: collect 2N bytes.
  - DIV: WIDTH iterations.
  - FIN: latch results.
  - TX: send 2N+1 bytes.
  - After TX the engine returns to RX.
- RX byte order: dividend bytes 0..N-1 (LSB first), then divisor bytes 0..N-1 (LSB first). A byte counter counts 0..2N-1.
- rx_valid outside RX: the byte is dropped and the byte counter is untouched.
- RX timeout: the idle counter resets on every accepted byte. If byte count > 0 and the idle counter reaches RX_TIMEOUT, the byte counter clears to 0 and the partial operands are discarded.
- When the 2N-th byte is accepted, the operands are complete.
  - Divisor nonzero: next state is DIV.
  - Divisor zero: next state is FIN directly.
- DIV uses a 2·WIDTH-bit partial-remainder register, initialised to {0, dividend}. Each cycle:
  - shift left by 1;
  - if upper half ≥ divisor, subtract the divisor from the upper half and shift 1 into the quotient; otherwise shift 0.
  - All comparisons are unsigned, WIDTH-bit.
- FIN: latch quotient, remainder and div_zero, and pulse done.
  - Divide-by-zero result: quotient = all ones, remainder = dividend, div_zero = 1.
- TX sequence:
  - quotient bytes LSB first;
  - remainder bytes LSB first;
  - status byte: 0x00 on success, 0xEE on divide-by-zero.
- tx_start rule: tx_start is issued in a cycle where tx_busy = 0 and the gap counter = 0. The gap counter loads TX_GAP-1 on each tx_start and decrements to 0.
- The cycle after the final tx_start the engine is in RX, with the byte counter at 0.

## Timing
- Reset values: tx_start 0, tx_data 0x00, quotient 0, remainder 0, div_zero 0, done 0, busy 0. State RX, all counters 0, gap counter 0.
- Let cycle k be the cycle where the last operand byte's rx_valid is high.
  - Divisor nonzero: DIV runs in cycles k+1..k+WIDTH; done is high in cycle k+WIDTH+1.
  - Divisor zero: done is high in cycle k+1.
- busy rises in cycle k+1 and falls in the cycle after the last tx_start.
- The first tx_start is in the cycle after done, if tx_busy = 0; otherwise it waits for tx_busy to go low.
- Consecutive tx_starts are at least TX_GAP cycles apart, and additionally wait while tx_busy = 1.
- quotient, remainder and div_zero change only in the done cycle. They hold through TX and the next RX.
- An rx_valid in the same cycle the RX timeout fires is accepted as byte 0 of a new frame.
- Reset mid-operation (any state) returns to the reset values immediately. No tx_start is emitted after rst asserts.

## Test plan
- WIDTH=16, TX_GAP=4, tx_busy=0, rx bytes E8 03 07 00 (1000/7):
  - done 17 cycles after the last byte;
  - quotient=0x008E, remainder=0x0006, div_zero=0;
  - tx bytes 8E 00 06 00 00, tx_start spaced exactly 4 cycles.
- WIDTH=16, rx 34 12 00 00:
  - done 1 cycle after the last byte;
  - quotient=0xFFFF, remainder=0x1234, div_zero=1;
  - tx FF FF 34 12 EE.
- RX_TIMEOUT=50: send E8 03, idle 60 cycles, then send 0A 00 05 00:
  - the partial frame is discarded;
  - quotient=0x0002, remainder=0x0000.
- Assert rst for 1 cycle during DIV (cycle k+5) of a 1000/7 frame:
  - all outputs go to their reset values;
  - no tx_start follows;
  - a new frame 64 00 0A 00 then yields quotient=10, remainder=0.
- WIDTH=32, rx FF FF FF FF 03 00 00 00:
  - quotient=0x55555555, remainder=0;
  - done at k+33;
  - 9 tx bytes.
- Hold tx_busy=1 for 20 cycles after done, and send 3 rx bytes during TX:
  - the first tx_start comes the cycle tx_busy falls;
  - the rx bytes are ignored;
  - the next frame decodes correctly.
